aes_mixcolumns_iter: RTL and testbench

AES_MIXCOLUMNS_ITER -- requirements
Module: aes_mixcolumns_iter

---
 rtl/aes_mixcolumns_iter.sv | 132 +++++++++++++
 tb/tb_aes_mixcolumns_iter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mixcolumns_iter.sv
// Iterative AES forward MixColumns. A captured 128-bit state is transformed
// COLS_PER_CYCLE columns per cycle into a result register, then held until
// the downstream handshake. A bypass flag (final round) copies columns through
// unchanged with identical timing.
module aes_mixcolumns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_bypass
);

    // Column counter step and the counter value seen on the final BUSY cycle.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_cfg_error
            $error("aes_mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    // Index 0 maps to bits [127:96], i.e. column 0 (bytes 0..3).
    logic [0:3][31:0] src_q, src_d;
    logic [0:3][31:0] res_q, res_d;
    logic             byp_q, byp_d;

    // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column; row 0 lives in the most significant byte.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        // NOTE: every signal driven here gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        src_d     = src_q;
        res_d     = res_q;
        byp_d     = byp_q;
        in_ready  = (state_q == IDLE) && rst_n;
        out_valid = (state_q == DONE) && rst_n;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d   = in_data;
                    byp_d   = in_bypass;
                    cnt_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    res_d[cnt_q + 2'(k)] = byp_q ? src_q[cnt_q + 2'(k)]
                                                 : mix_col(src_q[cnt_q + 2'(k)]);
                end
                // Counter holds on the last pass so it only wraps on BUSY entry.
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_STEP;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and visible result, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            res_q   <= '0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            byp_q   <= byp_d;
        end
    end

    // Captured input word.
    always_ff @(posedge clk) begin
        // NOTE: the source register is not reset; it is always written on
        // acceptance before BUSY reads it, so its reset value is never observed.
        src_q <= src_d;
    end

    assign out_data   = res_q;
    assign out_bypass = byp_q;

endmodule

// File: tb/tb_aes_mixcolumns_iter.sv
// Self-checking bench for aes_mixcolumns_iter: directed vectors, latency for
// all column widths, backpressure, mid-flight reset and a random scoreboard run.
module tb_aes_mixcolumns_iter;

    localparam int CPC = 1;
    localparam int L   = 4 / CPC;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_ready;

    logic         in_ready,   out_valid,   out_bypass;
    logic [127:0] out_data;
    logic         in_ready_2, out_valid_2, out_bypass_2;
    logic [127:0] out_data_2;
    logic         in_ready_4, out_valid_4, out_bypass_4;
    logic [127:0] out_data_4;

    always #5 clk = ~clk;

    aes_mixcolumns_iter #(.COLS_PER_CYCLE(CPC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_bypass(in_bypass), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_bypass(out_bypass));

    aes_mixcolumns_iter #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_2),
        .in_data(in_data), .in_bypass(in_bypass), .out_valid(out_valid_2),
        .out_ready(out_ready), .out_data(out_data_2), .out_bypass(out_bypass_2));

    aes_mixcolumns_iter #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
        .in_data(in_data), .in_bypass(in_bypass), .out_valid(out_valid_4),
        .out_ready(out_ready), .out_data(out_data_4), .out_bypass(out_bypass_4));

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
        logic         byp;
    } item_t;

    item_t sb[$];
    int    n_total = 0;
    int    n_pass  = 0;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN    = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V2_OUT   = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    // ---------------- reference model ----------------
    // Carry-less polynomial product, then reduction by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'(9'h11b) << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix product per column; row r uses coef[(j - r) mod 4].
    function automatic logic [127:0] mix_ref(input logic [127:0] d, input bit inverse);
        logic [7:0]   a[16];
        logic [7:0]   co[4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inverse) begin
            co[0] = 8'h0e; co[1] = 8'h0b; co[2] = 8'h0d; co[3] = 8'h09;
        end else begin
            co[0] = 8'h02; co[1] = 8'h03; co[2] = 8'h01; co[3] = 8'h01;
        end
        for (int i = 0; i < 16; i++) a[i] = d[127 - 8*i -: 8];
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(co[(j - row + 4) % 4], a[4*c + j]);
                r[127 - 8*(4*c + row) -: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [127:0] expect_of(input logic [127:0] d, input logic b);
        return b ? d : mix_ref(d, 1'b0);
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- monitor ----------------
    logic         pend = 1'b0;
    logic [127:0] pend_data;
    logic         pend_byp;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check1("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, pend_data);
                check1("hold_bypass", out_bypass, pend_byp);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL spurious_out: got word %h while none was expected", out_data);
                end else begin
                    item_t it;
                    it = sb.pop_front();
                    check("out_data", out_data, it.exp);
                    check1("out_bypass", out_bypass, it.byp);
                    if (!it.byp) check("inv_roundtrip", mix_ref(out_data, 1'b1), it.din);
                end
                pend = 1'b0;
            end else begin
                pend      = out_valid;
                pend_data = out_data;
                pend_byp  = out_bypass;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_word(input logic [127:0] d, input logic b, input bit push);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = d;
        in_bypass = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (push) sb.push_back('{din: d, exp: expect_of(d, b), byp: b});
            end
        end
        if (!ok) check1("send_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called right after the acceptance edge; cycle n is the n-th negedge.
    task automatic measure(output int l1, output int l2, output int l4,
                           output logic [127:0] d1, output logic [127:0] d2,
                           output logic [127:0] d4, output logic b1);
        l1 = -1; l2 = -1; l4 = -1;
        d1 = '0; d2 = '0; d4 = '0; b1 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (l1 < 0 && out_valid)   begin l1 = n; d1 = out_data; b1 = out_bypass; end
            if (l2 < 0 && out_valid_2) begin l2 = n; d2 = out_data_2; end
            if (l4 < 0 && out_valid_4) begin l4 = n; d4 = out_data_4; end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check_int("drain_empty", sb.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int           l1, l2, l4;
        logic [127:0] d1, d2, d4;
        logic         b1;
        logic         seen_valid;
        int           sent, cyc;
        bit           have;
        logic [127:0] w;
        logic         wb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bypass = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 128'h0);
        check1("rst_out_bypass", out_bypass, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check1("rel_in_ready", in_ready, 1'b1);

        // FIPS column vector, latency for all three widths
        send_word(FIPS_IN, 1'b0, 1'b1);
        measure(l1, l2, l4, d1, d2, d4, b1);
        check_int("fips_lat_c1", l1, L + 1);
        check_int("fips_lat_c2", l2, 4/2 + 1);
        check_int("fips_lat_c4", l4, 4/4 + 1);
        check("fips_data_c1", d1, FIPS_OUT);
        check("fips_data_c2", d2, FIPS_OUT);
        check("fips_data_c4", d4, FIPS_OUT);

        // Second vector, plain then bypassed
        send_word(V2_IN, 1'b0, 1'b1);
        measure(l1, l2, l4, d1, d2, d4, b1);
        check_int("v2_lat", l1, L + 1);
        check("v2_data", d1, V2_OUT);
        check1("v2_bypass", b1, 1'b0);
        send_word(V2_IN, 1'b1, 1'b1);
        measure(l1, l2, l4, d1, d2, d4, b1);
        check_int("v2byp_lat", l1, L + 1);
        check("v2byp_data", d1, V2_IN);
        check1("v2byp_bypass", b1, 1'b1);
        check("v2byp_data_c4", d4, V2_IN);

        // Backpressure in DONE with noisy upstream
        out_ready = 1'b0;
        send_word(FIPS_IN, 1'b0, 1'b1);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check1("bp_reach_done", out_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_bypass = 1'($urandom);
            @(negedge clk);
            check1("bp_in_ready", in_ready, 1'b0);
            check("bp_data", out_data, FIPS_OUT);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check1("bp_released", out_valid, 1'b0);
        check1("bp_idle_ready", in_ready, 1'b1);
        check("bp_out_hold", out_data, FIPS_OUT);
        check_int("bp_sb_empty", sb.size(), 0);
        seen_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        check1("bp_no_extra", seen_valid, 1'b0);

        // Reset during the second BUSY cycle
        send_word(V2_IN, 1'b0, 1'b0);
        seen_valid = 1'b0;
        @(negedge clk);
        seen_valid = seen_valid | out_valid;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
            @(posedge clk);
        end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check1("mrst_in_ready", in_ready, 1'b1);
        check("mrst_out_data", out_data, 128'h0);
        repeat (10) begin
            seen_valid = seen_valid | out_valid;
            @(negedge clk);
        end
        check1("mrst_no_valid", seen_valid, 1'b0);
        send_word(FIPS_IN, 1'b0, 1'b1);
        measure(l1, l2, l4, d1, d2, d4, b1);
        check("mrst_next_data", d1, FIPS_OUT);

        // Random traffic with random handshakes
        sent = 0;
        cyc  = 0;
        have = 1'b0;
        w    = '0;
        wb   = 1'b0;
        while (sent < 1000 && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
            out_ready = ($urandom_range(0, 9) < 7);
            if (!have) begin
                w    = {$urandom, $urandom, $urandom, $urandom};
                wb   = ($urandom_range(0, 3) == 0);
                have = 1'b1;
            end
            in_valid = ($urandom_range(0, 3) != 0);
            if (in_valid) begin
                in_data   = w;
                in_bypass = wb;
            end else begin
                in_data   = {$urandom, $urandom, $urandom, $urandom};
                in_bypass = 1'($urandom);
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back('{din: w, exp: expect_of(w, wb), byp: wb});
                have = 1'b0;
                sent++;
            end
        end
        check_int("rand_sent", sent, 1000);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
